// File: rtl/receptor_pkg.sv
// Shared definitions for the 5x7 matrix receiver.
// Holds the mode encoding of the {ch1,ch0} lines, the scanner state enum and
// the default matrix geometry.
package receptor_pkg;
  localparam int ROWS_DEF = 7;
  localparam int COLS_DEF = 5;

  localparam logic [1:0] MODO_HOLD   = 2'b00;
  localparam logic [1:0] MODO_SHIFT  = 2'b01;
  localparam logic [1:0] MODO_CLEAR  = 2'b10;
  localparam logic [1:0] MODO_FREEZE = 2'b11;

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} scan_state_t;
endpackage

// File: rtl/varredura_matriz.sv
// Column multiplexer for the LED matrix: clock divider, two-state scan FSM and
// the registered row/column drives.
// Ports:
//   clk, reset  system clock, async active-high reset
//   quadro      frame buffer, column c at bits [c*ROWS +: ROWS]
//   linhas      row drive (active-high) of the lit column
//   colunas     column enables, one-hot-low; all high while BLANK
module varredura_matriz
  import receptor_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS*ROWS-1:0] quadro,
  output logic [ROWS-1:0]      linhas,
  output logic [COLS-1:0]      colunas
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

  scan_state_t   state, state_nxt;
  logic [DW-1:0] div;
  logic [KW-1:0] k, k_nxt;
  logic          wrap;
  logic [ROWS-1:0] col_sel;
  logic [COLS-1:0] en_sel;

  assign wrap = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (wrap) div <= '0;
    else           div <= div + DW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // k is the column being shown; leaving BLANK shows column 0 first.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (wrap) begin
      if (state == BLANK) begin
        state_nxt = SCAN;
        k_nxt     = '0;
      end else begin
        k_nxt = (k == KW'(COLS - 1)) ? '0 : k + KW'(1);
      end
    end
  end

  always_comb begin
    col_sel = '0;
    en_sel  = '1;
    for (int c = 0; c < COLS; c++) begin
      if (k_nxt == KW'(c)) begin
        col_sel   = quadro[c*ROWS +: ROWS];
        en_sel[c] = 1'b0;
      end
    end
  end

  // Loads from the register value of quadro, so a commit on the same edge
  // shows up only at that column's next slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      linhas  <= '0;
      colunas <= '1;
    end else if (wrap) begin
      linhas  <= col_sel;
      colunas <= en_sel;
    end
  end
endmodule

// File: rtl/receptor_matriz_5x7.sv
// Serial-to-parallel receiver at the display end of the scrolling-text chain.
// Packs every ROWS sampled bits into a column, keeps the last COLS columns in
// a scrolling frame buffer and scans it onto the dot matrix.
// Ports:
//   clk, reset     system clock, async active-high reset
//   serial_in      serial data from the upstream register
//   ch1, ch0       mode: 00 hold, 01 shift, 10 clear, 11 freeze
//   linhas         row drive, active-high
//   colunas        column enable, one-hot-low
//   coluna_pronta  one-cycle pulse after a column is committed
//   indice_bit     bits currently held in the accumulator
module receptor_matriz_5x7
  import receptor_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int SCAN_DIV = 1000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serial_in,
  input  logic            ch1,
  input  logic            ch0,
  output logic [ROWS-1:0] linhas,
  output logic [COLS-1:0] colunas,
  output logic            coluna_pronta,
  output logic [2:0]      indice_bit
);
  logic [1:0]           modo;
  logic [ROWS-1:0]      acc, acc_nxt;
  logic [2:0]           cnt;
  logic [COLS*ROWS-1:0] quadro;
  logic                 amostra, fim, commit;

  assign modo    = {ch1, ch0};
  assign amostra = (modo == MODO_SHIFT) || (modo == MODO_FREEZE);
  assign fim     = amostra && (cnt == 3'(ROWS - 1));
  assign commit  = fim && (modo == MODO_SHIFT);
  // The completed word includes the bit sampled on this edge.
  assign acc_nxt = {acc[ROWS-2:0], serial_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      cnt           <= '0;
      quadro        <= '0;
      coluna_pronta <= 1'b0;
    end else if (modo == MODO_CLEAR) begin
      acc           <= '0;
      cnt           <= '0;
      quadro        <= '0;
      coluna_pronta <= 1'b0;
    end else begin
      coluna_pronta <= commit;
      if (amostra) begin
        acc <= acc_nxt;
        cnt <= fim ? 3'd0 : cnt + 3'd1;
      end
      // Column 0 drops off, the new word enters at column COLS-1.
      if (commit) quadro <= {acc_nxt, quadro[COLS*ROWS-1:ROWS]};
    end
  end

  assign indice_bit = cnt;

  varredura_matriz #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .SCAN_DIV(SCAN_DIV)
  ) u_varredura (
    .clk    (clk),
    .reset  (reset),
    .quadro (quadro),
    .linhas (linhas),
    .colunas(colunas)
  );
endmodule

// File: tb/tb_receptor_matriz_5x7.sv
module tb_receptor_matriz_5x7;
  import receptor_pkg::*;

  localparam int ROWS = 7;
  localparam int COLS = 5;
  localparam int SD   = 4;
  localparam int ALL1 = (1 << COLS) - 1;

  logic clk = 1'b0, reset = 1'b1, serial_in = 1'b0, ch1 = 1'b0, ch0 = 1'b0;
  logic [ROWS-1:0] linhas;
  logic [COLS-1:0] colunas;
  logic            coluna_pronta;
  logic [2:0]      indice_bit;

  int checks = 0, errors = 0;

  receptor_matriz_5x7 #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .ch1(ch1), .ch0(ch0),
    .linhas(linhas), .colunas(colunas), .coluna_pronta(coluna_pronta),
    .indice_bit(indice_bit)
  );

  always #5 clk = ~clk;

  // Reference model: word assembled as a number (first bit most significant),
  // frame as an array of column values, scan slot derived from edge count.
  int m_buf [COLS];
  int m_cnt, m_word, m_lin, m_col, m_pronta, m_t, m_k;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_buf[c]) m_buf[c] = 0;
      m_cnt = 0; m_word = 0; m_lin = 0; m_col = ALL1; m_pronta = 0; m_t = 0;
    end else begin
      m_t = m_t + 1;
      if (m_t % SD == 0) begin
        m_k   = (m_t / SD - 1) % COLS;
        m_lin = m_buf[m_k];
        m_col = ALL1 & ~(1 << m_k);
      end
      m_pronta = 0;
      if ({ch1, ch0} == MODO_CLEAR) begin
        foreach (m_buf[c]) m_buf[c] = 0;
        m_cnt = 0; m_word = 0;
      end else if (ch0) begin
        m_word = m_word * 2 + int'(serial_in);
        m_cnt  = m_cnt + 1;
        if (m_cnt == ROWS) begin
          if (!ch1) begin
            for (int c = 0; c < COLS - 1; c++) m_buf[c] = m_buf[c+1];
            m_buf[COLS-1] = m_word;
            m_pronta = 1;
          end
          m_cnt = 0; m_word = 0;
        end
      end
    end
  end

  // Stimulus helpers: called at a negedge, return at the next negedge.
  task automatic tick(input logic [1:0] md, input logic b);
    ch1 = md[1]; ch0 = md[0]; serial_in = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ch1 = 1'b0; ch0 = 1'b0; serial_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_cols(input logic [COLS-1:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * COLS * SD; i++) begin
      if (colunas === target) begin ok = 1'b1; break; end
      tick(MODO_HOLD, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [COLS-1:0] exp_c;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (linhas !== '0 || colunas !== '1 || coluna_pronta !== 1'b0 || indice_bit !== 3'd0) begin
      errors++;
      $display("FAIL reset_values got lin=%b col=%b pr=%b idx=%0d exp lin=0 col=11111 pr=0 idx=0",
               linhas, colunas, coluna_pronta, indice_bit);
    end
    reset = 1'b0;
    for (int n = 0; n <= 3 * SD; n++) begin
      exp_c = (n < SD) ? 5'b11111 : ~(5'b00001 << ((n / SD - 1) % COLS));
      checks++;
      if (colunas !== exp_c || linhas !== '0) begin
        errors++;
        $display("FAIL blank_scan n=%0d got col=%b lin=%b exp col=%b lin=0", n, colunas, linhas, exp_c);
      end
      tick(MODO_HOLD, 1'b0);
    end
  endtask

  task automatic test_single_column();
    logic [6:0] bits;
    bit ok;
    bits = 7'b1000001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(MODO_SHIFT, bits[6-i]);
      checks++;
      if (indice_bit !== 3'((i + 1) % 7) || coluna_pronta !== (i == 6)) begin
        errors++;
        $display("FAIL single_bit i=%0d got idx=%0d pr=%b exp idx=%0d pr=%b",
                 i, indice_bit, coluna_pronta, (i + 1) % 7, i == 6);
      end
    end
    tick(MODO_HOLD, 1'b0);
    checks++;
    if (coluna_pronta !== 1'b0) begin
      errors++; $display("FAIL single_pulse_len got pr=%b exp 0", coluna_pronta);
    end
    wait_cols(5'b01111, ok);
    checks++;
    if (!ok || linhas !== 7'b1000001 || 32'(linhas) !== m_lin) begin
      errors++;
      $display("FAIL single_show ok=%b got lin=%b exp 1000001 model=%0h", ok, linhas, m_lin);
    end
  endtask

  task automatic test_six_columns();
    logic [6:0] words [6];
    logic [6:0] expc  [COLS];
    logic [6:0] w;
    int pulses, k;
    words = '{7'h7F, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    expc  = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    pulses = 0;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      w = words[j];
      for (int b = 6; b >= 0; b--) begin
        tick(MODO_SHIFT, w[b]);
        if (coluna_pronta === 1'b1) pulses++;
      end
    end
    tick(MODO_HOLD, 1'b0);
    if (coluna_pronta === 1'b1) pulses++;
    checks++;
    if (pulses != 6) begin
      errors++; $display("FAIL six_pulses got %0d exp 6", pulses);
    end
    for (int i = 0; i < (COLS + 1) * SD; i++) begin
      tick(MODO_HOLD, 1'b0);
      if (colunas !== 5'b11111) begin
        k = 0;
        for (int c = 0; c < COLS; c++) if (!colunas[c]) k = c;
        checks++;
        if (linhas !== expc[k]) begin
          errors++; $display("FAIL six_col k=%0d got %h exp %h", k, linhas, expc[k]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int pulses, k;
    logic [6:0] e;
    pulses = 0;
    for (int i = 0; i < 4; i++) tick(MODO_SHIFT, 1'($urandom_range(0, 1)));
    checks++;
    if (indice_bit !== 3'd4) begin
      errors++; $display("FAIL clear_pre_idx got %0d exp 4", indice_bit);
    end
    tick(MODO_CLEAR, 1'($urandom_range(0, 1)));
    checks++;
    if (indice_bit !== 3'd0 || coluna_pronta !== 1'b0) begin
      errors++; $display("FAIL clear_idx got idx=%0d pr=%b exp 0 0", indice_bit, coluna_pronta);
    end
    for (int i = 0; i < 7; i++) begin
      tick(MODO_SHIFT, 1'b1);
      if (coluna_pronta === 1'b1) pulses++;
    end
    tick(MODO_HOLD, 1'b0);
    if (coluna_pronta === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL clear_pulses got %0d exp 1", pulses);
    end
    for (int i = 0; i < (COLS + 1) * SD; i++) begin
      tick(MODO_HOLD, 1'b0);
      if (colunas !== 5'b11111) begin
        k = 0;
        for (int c = 0; c < COLS; c++) if (!colunas[c]) k = c;
        e = (k == COLS - 1) ? 7'h7F : 7'h00;
        checks++;
        if (linhas !== e) begin
          errors++; $display("FAIL clear_col k=%0d got %h exp %h", k, linhas, e);
        end
      end
    end
  endtask

  task automatic test_freeze();
    int wraps, k;
    logic [2:0] prev;
    logic [6:0] e;
    wraps = 0;
    prev = indice_bit;
    for (int i = 0; i < 14; i++) begin
      tick(MODO_FREEZE, 1'($urandom_range(0, 1)));
      checks++;
      if (indice_bit !== 3'((i + 1) % 7) || coluna_pronta !== 1'b0) begin
        errors++;
        $display("FAIL freeze_bit i=%0d got idx=%0d pr=%b exp idx=%0d pr=0",
                 i, indice_bit, coluna_pronta, (i + 1) % 7);
      end
      if (prev == 3'd6 && indice_bit == 3'd0) wraps++;
      prev = indice_bit;
    end
    checks++;
    if (wraps != 2) begin
      errors++; $display("FAIL freeze_wraps got %0d exp 2", wraps);
    end
    for (int i = 0; i < (COLS + 1) * SD; i++) begin
      tick(MODO_HOLD, 1'b0);
      if (colunas !== 5'b11111) begin
        k = 0;
        for (int c = 0; c < COLS; c++) if (!colunas[c]) k = c;
        e = (k == COLS - 1) ? 7'h7F : 7'h00;
        checks++;
        if (linhas !== e) begin
          errors++; $display("FAIL freeze_col k=%0d got %h exp %h", k, linhas, e);
        end
      end
    end
  endtask

  task automatic test_mode_pause();
    logic [6:0] w;
    bit ok;
    w = 7'($urandom_range(0, 127));
    for (int i = 0; i < 3; i++) tick(MODO_SHIFT, w[6-i]);
    for (int i = 0; i < 5; i++) begin
      tick(MODO_HOLD, 1'($urandom_range(0, 1)));
      checks++;
      if (indice_bit !== 3'd3) begin
        errors++; $display("FAIL pause_idx got %0d exp 3", indice_bit);
      end
    end
    for (int i = 3; i < 7; i++) tick(MODO_SHIFT, w[6-i]);
    checks++;
    if (indice_bit !== 3'd0 || coluna_pronta !== 1'b1) begin
      errors++; $display("FAIL pause_commit got idx=%0d pr=%b exp 0 1", indice_bit, coluna_pronta);
    end
    wait_cols(5'b01111, ok);
    checks++;
    if (!ok || linhas !== w) begin
      errors++; $display("FAIL pause_col4 ok=%b got %h exp %h", ok, linhas, w);
    end
    wait_cols(5'b10111, ok);
    checks++;
    if (!ok || linhas !== 7'h7F) begin
      errors++; $display("FAIL pause_col3 ok=%b got %h exp 7f", ok, linhas);
    end
  endtask

  task automatic test_random();
    int r;
    logic [1:0] md;
    do_reset();
    for (int i = 0; i < 600 + 2 * COLS * SD; i++) begin
      r = $urandom_range(0, 19);
      md = (i >= 600) ? MODO_HOLD : (r == 0) ? MODO_CLEAR : (r < 3) ? MODO_HOLD :
           (r < 6) ? MODO_FREEZE : MODO_SHIFT;
      tick(md, 1'($urandom_range(0, 1)));
      checks++;
      if (32'(linhas) !== m_lin || 32'(colunas) !== m_col ||
          32'(coluna_pronta) !== m_pronta || 32'(indice_bit) !== m_cnt) begin
        errors++;
        $display("FAIL random i=%0d got lin=%h col=%b pr=%b idx=%0d exp lin=%h col=%b pr=%0d idx=%0d",
                 i, linhas, colunas, coluna_pronta, indice_bit, m_lin, 5'(m_col), m_pronta, m_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [6:0] w;
    w = 7'h55;
    for (int i = 0; i < 7; i++) tick(MODO_SHIFT, w[6-i]);
    for (int i = 0; i < 3; i++) tick(MODO_SHIFT, 1'b1);
    wait_cols(5'b11011, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL async_reach_k2 got col=%b exp 11011", colunas);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (colunas !== 5'b11111 || linhas !== '0 || indice_bit !== 3'd0 || coluna_pronta !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got col=%b lin=%h idx=%0d pr=%b exp 11111 0 0 0",
               colunas, linhas, indice_bit, coluna_pronta);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n <= SD; n++) begin
      checks++;
      if (colunas !== ((n < SD) ? 5'b11111 : 5'b11110)) begin
        errors++; $display("FAIL async_blank n=%0d got col=%b", n, colunas);
      end
      tick(MODO_HOLD, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_single_column();
    test_six_columns();
    test_clear();
    test_freeze();
    test_mode_pause();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
